// File: rtl/serial_fifo_ctrl.sv
// Memory-mapped serial port controller: RX/TX byte FIFOs in front of a UART,
// with register access (DATA/STATUS/CTRL), overrun tracking and an interrupt.
module serial_fifo_ctrl #(
    parameter int         DEPTH_LOG2    = 4,
    parameter logic [7:0] RX_THRESH_RST = 8'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        readEnable_i,
    input  logic [1:0]  regSel_i,
    input  logic [31:0] dataSave_i,
    output logic [31:0] dataLoad_o,
    output logic        int_o,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o
);
    localparam int              DEPTH    = 1 << DEPTH_LOG2;
    localparam int              CW       = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]      DEPTH8   = 8'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} tx_state_t;

    tx_state_t state, state_nxt;

    logic en_q, strobe, acc_rd, acc_wr;
    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_push, rx_pop, tx_push, tx_pop, ovr, ovr_set, stat_rd;
    logic rx_int_en, tx_int_en;
    logic [7:0] rx_thresh, eff_thresh;
    logic start_nxt;
    logic unused_bits;

    // Only the first cycle of an enable run counts as an access.
    assign strobe = enable_i & ~en_q;
    assign acc_rd = strobe & readEnable_i;
    assign acc_wr = strobe & ~readEnable_i;

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign rx_pop  = acc_rd & (regSel_i == 2'd0) & ~rx_empty;
    assign rx_push = rxdReady_i & (~rx_full | rx_pop);
    assign ovr_set = rxdReady_i & rx_full & ~rx_pop;
    assign stat_rd = acc_rd & (regSel_i == 2'd1);
    assign tx_push = acc_wr & (regSel_i == 2'd0) & ~tx_full;
    assign tx_pop  = (state == SEND);

    assign start_nxt   = (state == IDLE) && (state_nxt == SEND);
    assign unused_bits = ^dataSave_i[31:16];

    // Access edge detector.
    always_ff @(posedge clk) begin
        if (rst) en_q <= 1'b0;
        else     en_q <= enable_i;
    end

    // FIFO storage; contents need no reset since counts gate every read.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rxdData_i;
        if (tx_push) tx_mem[tx_wp] <= dataSave_i[7:0];
    end

    // FIFO pointers, counts and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            ovr    <= 1'b0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            // A fresh overrun wins over the clear-on-read.
            ovr <= ovr_set | (ovr & ~stat_rd);
        end
    end

    // Control register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_int_en <= 1'b1;
            tx_int_en <= 1'b0;
            rx_thresh <= RX_THRESH_RST;
        end else if (acc_wr && regSel_i == 2'd2) begin
            rx_int_en <= dataSave_i[0];
            tx_int_en <= dataSave_i[1];
            rx_thresh <= dataSave_i[15:8];
        end
    end

    // Threshold as used by the interrupt: clamped to 1..DEPTH.
    always_comb begin
        eff_thresh = rx_thresh;
        if (rx_thresh == 8'd0)       eff_thresh = 8'd1;
        else if (rx_thresh > DEPTH8) eff_thresh = DEPTH8;
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // TX next-state: hand one byte to the UART, then track its busy pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!tx_empty && !txdBusy_i) state_nxt = SEND;
            SEND:    state_nxt = WAIT_HI;
            WAIT_HI: if (txdBusy_i) state_nxt = WAIT_LO;
            WAIT_LO: if (!txdBusy_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Start pulse and data are registered on entry to SEND so both are valid in SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            txdStart_o <= 1'b0;
            txdData_o  <= 8'h00;
        end else begin
            txdStart_o <= start_nxt;
            if (start_nxt) txdData_o <= tx_mem[tx_rp];
        end
    end

    // Registered level interrupt.
    always_ff @(posedge clk) begin
        if (rst) int_o <= 1'b0;
        else     int_o <= (rx_int_en & ((9'(rx_cnt) >= {1'b0, eff_thresh}) | ovr))
                        | (tx_int_en & tx_empty & (state == IDLE));
    end

    // Register read mux.
    always_comb begin
        dataLoad_o = 32'h0;
        case (regSel_i)
            2'd0: if (!rx_empty) dataLoad_o = {24'h0, rx_mem[rx_rp]};
            2'd1: dataLoad_o = {8'h0, 8'(tx_cnt), 8'(rx_cnt), 3'b000, ovr,
                                tx_empty, rx_full, ~tx_full, ~rx_empty};
            2'd2: dataLoad_o = {16'h0, rx_thresh, 6'h00, tx_int_en, rx_int_en};
            default: dataLoad_o = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Scoreboard bench for serial_fifo_ctrl: stimulus queues expected values,
// a negedge monitor compares them against the DUT outputs.
module tb_serial_fifo_ctrl;
    localparam int K_DATA  = 0;
    localparam int K_INT   = 1;
    localparam int K_START = 2;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i, readEnable_i;
    logic [1:0]  regSel_i;
    logic [31:0] dataSave_i, dataLoad_o;
    logic        int_o, rxdReady_i, txdBusy_i, txdStart_o;
    logic [7:0]  rxdData_i, txdData_o;

    chk_t       exp_q[$];
    logic [7:0] tx_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    serial_fifo_ctrl #(.DEPTH_LOG2(4), .RX_THRESH_RST(8'd1)) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .readEnable_i(readEnable_i),
        .regSel_i(regSel_i), .dataSave_i(dataSave_i), .dataLoad_o(dataLoad_o),
        .int_o(int_o), .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i),
        .txdBusy_i(txdBusy_i), .txdStart_o(txdStart_o), .txdData_o(txdData_o)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk(input int kind, input string name, input logic [31:0] exp);
        chk_t c;
        c.kind = kind;
        c.name = name;
        c.exp  = exp;
        exp_q.push_back(c);
    endtask

    // Monitor: drains pending expectations and checks every transmit start.
    initial begin
        chk_t c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                case (c.kind)
                    K_DATA:  act = dataLoad_o;
                    K_INT:   act = 32'(int_o);
                    default: act = 32'(txdStart_o);
                endcase
                compare(c.name, act, c.exp);
            end
            if (txdStart_o) begin
                if (tx_q.size() == 0) compare("unexpected_start", 32'(txdStart_o), 32'h0);
                else begin
                    compare("tx_data", 32'(txdData_o), 32'(tx_q.pop_front()));
                    compare("start_while_busy", 32'(txdBusy_i), 32'h0);
                end
            end
        end
    end

    // Transmitter model: busy for 10 cycles after each start.
    initial begin
        txdBusy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (txdStart_o) begin
                @(posedge clk); #1 txdBusy_i = 1'b1;
                repeat (10) @(posedge clk);
                #1 txdBusy_i = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [1:0] sel, input logic [31:0] exp, input string name);
        enable_i = 1'b1; readEnable_i = 1'b1; regSel_i = sel;
        chk(K_DATA, name, exp);
        cyc();
        enable_i = 1'b0;
        cyc();
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        enable_i = 1'b1; readEnable_i = 1'b0; regSel_i = sel; dataSave_i = d;
        cyc();
        enable_i = 1'b0;
        cyc();
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rxdReady_i = 1'b1; rxdData_i = d;
        cyc();
        rxdReady_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; enable_i = 1'b0; readEnable_i = 1'b0; regSel_i = 2'd1;
        dataSave_i = '0; rxdReady_i = 1'b0; rxdData_i = '0;
        cyc(); cyc(); cyc();
        chk(K_DATA, "rst_status", 32'h0000_000A);
        chk(K_INT, "rst_int", 32'h0);
        chk(K_START, "rst_start", 32'h0);
        cyc();
        rst = 1'b0;
        cyc();

        // Reset register contents and reserved register.
        rd(2'd2, 32'h0000_0101, "ctrl_rst");
        rd(2'd0, 32'h0, "data_empty");
        rd(2'd3, 32'h0, "reg3_rd");
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd2, 32'h0000_0101, "ctrl_after_reg3_wr");
        rd(2'd1, 32'h0000_000A, "status_after_reg3_wr");

        // Single RX byte raises the interrupt two cycles later.
        rx_pulse(8'h41);
        chk(K_INT, "int_c1", 32'h0);
        cyc();
        chk(K_INT, "int_c2", 32'h1);
        cyc();
        rd(2'd0, 32'h0000_0041, "rx_data");
        rd(2'd1, 32'h0000_000A, "status_rx_empty");

        // Overflow with 17 bytes.
        for (int i = 0; i < 17; i++) begin
            rxdReady_i = 1'b1; rxdData_i = 8'(8'h10 + i);
            cyc();
        end
        rxdReady_i = 1'b0;
        rd(2'd1, 32'h0000_101F, "status_ovr");
        rd(2'd1, 32'h0000_100F, "status_ovr_clr");

        // Enable held for 5 cycles pops once.
        enable_i = 1'b1; readEnable_i = 1'b1; regSel_i = 2'd0;
        chk(K_DATA, "hold_first", 32'h10);
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk(K_DATA, "hold_later", 32'h11);
            cyc();
        end
        enable_i = 1'b0;
        cyc();
        rd(2'd1, 32'h0000_0F0B, "status_one_pop");
        do_reset();
        rd(2'd1, 32'h0000_000A, "status_after_rst");

        // Overrun coinciding with a STATUS read keeps OVR; push+pop while full.
        for (int i = 0; i < 16; i++) begin
            rxdReady_i = 1'b1; rxdData_i = 8'(8'h20 + i);
            cyc();
        end
        rxdData_i = 8'hEE;
        enable_i = 1'b1; readEnable_i = 1'b1; regSel_i = 2'd1;
        chk(K_DATA, "status_ovr_race", 32'h0000_100F);
        cyc();
        rxdReady_i = 1'b0; enable_i = 1'b0;
        cyc();
        rd(2'd1, 32'h0000_101F, "ovr_kept");
        rd(2'd1, 32'h0000_100F, "ovr_clr2");
        rxdReady_i = 1'b1; rxdData_i = 8'h99;
        enable_i = 1'b1; readEnable_i = 1'b1; regSel_i = 2'd0;
        chk(K_DATA, "full_pushpop", 32'h20);
        cyc();
        rxdReady_i = 1'b0; enable_i = 1'b0;
        cyc();
        rd(2'd1, 32'h0000_100F, "full_pushpop_status");
        for (int i = 1; i < 16; i++) rd(2'd0, 32'(8'h20 + i), "drain");
        rd(2'd0, 32'h99, "drain_last");
        rd(2'd1, 32'h0000_000A, "drained");

        // Two TX bytes, second one only after busy falls.
        enable_i = 1'b1; readEnable_i = 1'b0; regSel_i = 2'd0; dataSave_i = 32'h55;
        tx_q.push_back(8'h55);
        chk(K_START, "start_w0", 32'h0);
        cyc();
        enable_i = 1'b0;
        chk(K_START, "start_w1", 32'h0);
        cyc();
        chk(K_START, "start_w2", 32'h1);
        cyc();
        tx_q.push_back(8'hAA);
        wr(2'd0, 32'hAA);
        rd(2'd1, 32'h0001_0002, "status_tx_q1");
        for (int n = 0; n < 300; n++) begin
            if (tx_q.size() == 0 && !txdBusy_i) break;
            cyc();
        end
        compare("tx_drain", 32'(tx_q.size()), 32'h0);
        cyc(); cyc();
        rd(2'd1, 32'h0000_000A, "status_tx_done");

        // Interrupt sources and threshold clamping.
        wr(2'd2, 32'h0000_0302);
        rd(2'd2, 32'h0000_0302, "ctrl_rd");
        rx_pulse(8'h01);
        rx_pulse(8'h02);
        cyc(); cyc();
        chk(K_INT, "int_tx_empty", 32'h1);
        cyc();
        wr(2'd2, 32'h0000_0301);
        cyc();
        chk(K_INT, "int_below_thr", 32'h0);
        cyc();
        rx_pulse(8'h03);
        chk(K_INT, "int_thr_c1", 32'h0);
        cyc();
        chk(K_INT, "int_thr_c2", 32'h1);
        cyc();
        wr(2'd2, 32'h0000_FF01);
        rd(2'd2, 32'h0000_FF01, "ctrl_thr_ff");
        cyc();
        chk(K_INT, "int_thr_clamp_hi", 32'h0);
        cyc();
        wr(2'd2, 32'h0000_0001);
        cyc();
        chk(K_INT, "int_thr_zero", 32'h1);
        cyc();
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'h0000_FF03, "ctrl_mask");

        // Reset in WAIT_LO with three bytes queued.
        do_reset();
        tx_q.push_back(8'h01);
        wr(2'd0, 32'h01);
        wr(2'd0, 32'h02);
        wr(2'd0, 32'h03);
        wr(2'd0, 32'h04);
        rd(2'd1, 32'h0003_0002, "status_tx_q3");
        rst = 1'b1;
        chk(K_START, "rst_mid_start", 32'h0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        rd(2'd1, 32'h0000_000A, "status_rst_tx");
        repeat (30) cyc();
        compare("tx_all_started", 32'(tx_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
